// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter granting the shared L2 bus side to one L1 requester per cache block,
// with a per-grant watchdog that forcibly releases a stalled transfer.
module bus_req_arbiter #(
  parameter  int NUM_CPUS         = 8,
  parameter  int BLOCK_SIZE_WORDS = 2,
  parameter  int TIMEOUT          = 25,
  localparam int IDW = $clog2(NUM_CPUS),
  localparam int BIW = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NUM_CPUS-1:0] req,
  input  logic                beat,
  output logic [NUM_CPUS-1:0] grant,
  output logic                grant_valid,
  output logic [IDW-1:0]      grant_id,
  output logic [BIW-1:0]      beat_idx,
  output logic                last_beat,
  output logic                timeout_err
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BLOCK_SIZE_WORDS - 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic [NUM_CPUS-1:0]   grant_nxt;
  logic                  grant_valid_nxt;
  logic [IDW-1:0]        grant_id_nxt;
  logic [BIW-1:0]        beat_idx_nxt;
  logic [WDW-1:0]        wdog, wdog_nxt;
  logic [IDW-1:0]        rr_ptr, rr_ptr_nxt;
  logic                  timeout_err_nxt;
  logic [IDW-1:0]        pick_base;
  logic                  win_found;
  logic [IDW-1:0]        win_id;
  logic                  release_now;

  // On release the just-finished CPU becomes the pointer, so it gets lowest priority.
  assign pick_base = (state == BUSY) ? grant_id : rr_ptr;

  // Descending scan: the last hit kept is the one nearest after pick_base.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_CPUS; i >= 1; i--) begin
      if (req[(int'(pick_base) + i) % NUM_CPUS]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(pick_base) + i) % NUM_CPUS);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    grant_id_nxt    = grant_id;
    beat_idx_nxt    = beat_idx;
    wdog_nxt        = wdog;
    rr_ptr_nxt      = rr_ptr;
    timeout_err_nxt = 1'b0;
    release_now     = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt       = BUSY;
          grant_nxt       = NUM_CPUS'(1) << win_id;
          grant_valid_nxt = 1'b1;
          grant_id_nxt    = win_id;
          beat_idx_nxt    = '0;
          wdog_nxt        = '0;
        end
      end
      BUSY: begin
        if (beat) begin
          wdog_nxt = '0;
          if (beat_idx == LAST_IDX) release_now = 1'b1;
          else                      beat_idx_nxt = beat_idx + BIW'(1);
        end else if (wdog == WD_MAX) begin
          release_now     = 1'b1;
          timeout_err_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + WDW'(1);
        end

        if (release_now) begin
          rr_ptr_nxt   = grant_id;
          beat_idx_nxt = '0;
          wdog_nxt     = '0;
          if (win_found) begin
            grant_nxt       = NUM_CPUS'(1) << win_id;
            grant_valid_nxt = 1'b1;
            grant_id_nxt    = win_id;
          end else begin
            state_nxt       = IDLE;
            grant_nxt       = '0;
            grant_valid_nxt = 1'b0;
            grant_id_nxt    = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_idx    <= '0;
      wdog        <= '0;
      rr_ptr      <= IDW'(NUM_CPUS - 1);
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      beat_idx    <= beat_idx_nxt;
      wdog        <= wdog_nxt;
      rr_ptr      <= rr_ptr_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  assign last_beat = grant_valid & beat & (beat_idx == LAST_IDX);

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed and randomized checks of bus_req_arbiter against a block-level behavioural model.
module tb_bus_req_arbiter;
  localparam int N = 8;
  localparam int B = 2;
  localparam int T = 25;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [N-1:0] req;
  logic         beat;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;
  logic [0:0]   beat_idx;
  logic         last_beat;
  logic         timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  // model: current owner (-1 idle), last winner, beat index, beat-less cycle count
  int m_cur, m_ptr, m_idx, m_stall;
  bit m_tout;

  bus_req_arbiter #(.NUM_CPUS(N), .BLOCK_SIZE_WORDS(B), .TIMEOUT(T)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .beat(beat),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .beat_idx(beat_idx), .last_beat(last_beat), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    m_cur = -1; m_ptr = N - 1; m_idx = 0; m_stall = 0; m_tout = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic b);
    bit done;
    done   = 0;
    m_tout = 0;
    if (m_cur < 0) begin
      m_cur = rr_pick(r, m_ptr);
      m_idx = 0; m_stall = 0;
    end else if (b) begin
      m_stall = 0;
      if (m_idx == B - 1) done = 1;
      else m_idx++;
    end else begin
      m_stall++;
      if (m_stall == T) begin done = 1; m_tout = 1; end
    end
    if (done) begin
      m_ptr = m_cur; m_idx = 0; m_stall = 0;
      m_cur = rr_pick(r, m_ptr);
    end
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".grant"},       32'(grant),       (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
    chk({tag, ".grant_valid"}, 32'(grant_valid), (m_cur >= 0) ? 32'd1 : 32'd0);
    chk({tag, ".grant_id"},    32'(grant_id),    (m_cur >= 0) ? 32'(m_cur) : 32'd0);
    chk({tag, ".beat_idx"},    32'(beat_idx),    32'(m_idx));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_tout));
  endtask

  // one clock: drive inputs mid-cycle, check combinational output, clock, check registers
  task automatic cyc(input logic [N-1:0] r, input logic b, input string tag);
    req = r; beat = b;
    #1;
    chk({tag, ".last_beat"}, 32'(last_beat),
        ((m_cur >= 0) && b && (m_idx == B - 1)) ? 32'd1 : 32'd0);
    @(posedge CLK);
    model_step(r, b);
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(input logic [N-1:0] r, input logic b);
    req = r; beat = b;
    nRST = 1'b0;
    model_reset();
    #1;
    check_outs("rst_async");
    @(posedge CLK);
    #1;
    check_outs("rst_hold");
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1; req = '0; beat = 1'b0;
    model_reset();
    #2;

    // reset with everything requesting, then full contention
    do_reset(8'hFF, 1'b1);
    cyc(8'hFF, 1'b1, "rst_first");
    chk("rst_first_grant", 32'(grant), 32'h01);
    for (int k = 0; k < 16; k++) cyc(8'hFF, 1'b1, "contend");
    chk("contend_wrap_id", 32'(grant_id), 32'd0);

    // single requester, drops req during its last beat
    do_reset(8'h00, 1'b0);
    cyc(8'h08, 1'b0, "single_gnt");
    chk("single_id", 32'(grant_id), 32'd3);
    cyc(8'h08, 1'b1, "single_b0");
    chk("single_idx1", 32'(beat_idx), 32'd1);
    cyc(8'h00, 1'b1, "single_b1");
    chk("single_released", 32'(grant), 32'd0);
    cyc(8'h00, 1'b1, "idle_beat");

    // round-robin pointer after CPU5
    do_reset(8'h00, 1'b0);
    cyc(8'h20, 1'b0, "rr_g5");
    cyc(8'h20, 1'b1, "rr_b0");
    cyc(8'h44, 1'b1, "rr_b1");
    chk("rr_next6", 32'(grant_id), 32'd6);
    cyc(8'h44, 1'b1, "rr_6b0");
    cyc(8'h44, 1'b1, "rr_6b1");
    chk("rr_next2", 32'(grant_id), 32'd2);

    // watchdog expiry with CPU2 pending
    do_reset(8'h00, 1'b0);
    cyc(8'h02, 1'b0, "wd_g1");
    for (int k = 0; k < T - 1; k++) cyc(8'h06, 1'b0, "wd_stall");
    chk("wd_still_held", 32'(grant_id), 32'd1);
    cyc(8'h06, 1'b0, "wd_expire");
    chk("wd_terr", 32'(timeout_err), 32'd1);
    chk("wd_regrant2", 32'(grant_id), 32'd2);
    cyc(8'h04, 1'b1, "wd_after");
    chk("wd_terr_pulse", 32'(timeout_err), 32'd0);

    // beat on the final permitted cycle beats the watchdog
    do_reset(8'h00, 1'b0);
    cyc(8'h02, 1'b0, "wd2_g1");
    for (int k = 0; k < T - 1; k++) cyc(8'h06, 1'b0, "wd2_stall");
    cyc(8'h06, 1'b1, "wd2_beat");
    chk("wd2_no_terr", 32'(timeout_err), 32'd0);
    chk("wd2_idx1", 32'(beat_idx), 32'd1);

    // asynchronous reset mid-transfer
    do_reset(8'h00, 1'b0);
    cyc(8'h10, 1'b0, "mid_g4");
    cyc(8'h10, 1'b1, "mid_b0");
    #2;
    do_reset(8'h10, 1'b0);
    cyc(8'h10, 1'b0, "mid_regrant");
    chk("mid_regrant_id", 32'(grant_id), 32'd4);

    // randomized traffic with phases of sparse beats to reach the watchdog
    do_reset(8'h00, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      logic         b;
      r = N'($urandom);
      if ($urandom_range(3) == 0) r = '0;
      if ((k / 300) % 2 == 1) b = ($urandom_range(39) == 0);
      else                    b = ($urandom_range(1) == 1);
      cyc(r, b, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/bus_req_arbiter.md
# bus_req_arbiter

Round-robin arbiter that shares the single L2 side of the coherence bus controller among NUM_CPUS L1 cache requesters. Grants exactly one CPU at a time, holds the grant for one full cache block (BLOCK_SIZE_WORDS data beats), and supplies the word index used by the bus datapath. A per-grant watchdog forcibly releases a grant whose transfer stalls, so one hung requester cannot block the bus.

## Interface
- NUM_CPUS, default 8: number of requesting caches, ≥2.
- BLOCK_SIZE_WORDS, default 2: beats per block transfer, ≥1.
- TIMEOUT, default 25: maximum consecutive beat-less BUSY cycles before forced release, ≥2.
- CLK  in  1: single clock, rising edge.
- nRST  in  1: asynchronous, active-low reset.
- req  in  NUM_CPUS: per-CPU request, level; held by requester until its block completes.
- beat  in  1: one word moved between the granted CPU and L2 this cycle.
- grant  out  NUM_CPUS: one-hot grant, registered; all-zero when idle.
- grant_valid  out  1: OR of grant, registered.
- grant_id  out  $clog2(NUM_CPUS): index of granted CPU; 0 when idle.
- beat_idx  out  max(1,$clog2(BLOCK_SIZE_WORDS)): word index of the current beat, 0..BLOCK_SIZE_WORDS-1.
- last_beat  out  1: combinational; grant_valid & beat & (beat_idx == BLOCK_SIZE_WORDS-1).
- timeout_err  out  1: one-cycle registered pulse on forced release.

## Operation
- States: IDLE, BUSY. Internal: rr_ptr (last winner), beat_idx counter, wdog counter.
- Winner selection: first CPU with req set, searching rr_ptr+1, rr_ptr+2, … modulo NUM_CPUS (wrap-around from NUM_CPUS-1 to 0).
- IDLE: if any req, load grant/grant_id with winner, clear beat_idx and wdog, go BUSY. Else stay IDLE, outputs zero.
- BUSY, beat=1: wdog cleared. If beat_idx==BLOCK_SIZE_WORDS-1 (completion): rr_ptr ← grant_id; beat_idx ← 0; if any other req, winner computed with updated pointer (current CPU lowest priority) is granted on the same edge (no bubble) and stay BUSY; else grant cleared, go IDLE. Otherwise beat_idx increments.
- BUSY, beat=0: wdog increments. When wdog==TIMEOUT-1: forced release — rr_ptr ← grant_id, timeout_err ← 1 next cycle, beat_idx and wdog cleared, then same re-grant/IDLE decision as completion.
- beat and timeout in the same cycle: beat wins; no timeout.
- req dropped by the granted CPU while BUSY: ignored; grant held until completion or timeout.
- beat while IDLE: ignored, no state change.
- A CPU whose grant completed is re-granted on the next edge only if no other CPU requests (sole requester: back-to-back grants to itself).

## Timing
- Reset values: grant=0, grant_valid=0, grant_id=0, beat_idx=0, timeout_err=0, state IDLE, rr_ptr=NUM_CPUS-1 (CPU0 has first priority), wdog=0.
- nRST low mid-transfer: all above values immediately (asynchronous); the partial block is abandoned, no timeout_err.
- req→grant latency: 1 cycle from IDLE (req sampled at edge N, grant visible after edge N).
- Grant duration with beats every cycle: exactly BLOCK_SIZE_WORDS cycles; next grant visible the cycle after last_beat.
- Forced release: grant held exactly TIMEOUT beat-less cycles; timeout_err high in the first cycle after release, concurrent with any new grant.
- Full contention throughput: one block per BLOCK_SIZE_WORDS cycles with continuous beats; each CPU waits at most NUM_CPUS-1 grants.

## Test plan
- Reset: hold nRST low with req=8'hFF, beat=1 → all outputs 0; release nRST → grant=8'h01 one cycle later.
- Single requester: req=8'h08 held, beat high from the cycle after grant → grant_id=3 for 2 cycles, beat_idx 0 then 1, last_beat on the second, grant=0 next cycle.
- Full contention: req=8'hFF, beat=1 continuously → grant_id sequence 0,1,2,…,7,0, each held 2 cycles, no idle cycle between grants.
- Round-robin pointer: after CPU5 completes, req=8'h44 (CPUs 2 and 6) → CPU6 granted, then CPU2.
- Watchdog: CPU1 granted, beat=0 for 25 cycles → grant drops after cycle 25, timeout_err pulses one cycle, pending CPU2 granted same cycle; repeat with beat on the 25th cycle → no timeout, beat_idx=1.
- Reset mid-transfer: CPU4 granted, beat_idx=1, assert nRST → outputs 0 immediately, timeout_err stays 0; after release with req=8'h10 → CPU4 regranted with beat_idx=0.
